// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row strobe, per-key debounce, one-shot emit, release wait.
// Define KEYPAD_FUNC_EN to emit '*'/'#' as key_func pulses; otherwise they are swallowed.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [2:0] i_col_in,
  output logic [3:0] o_row_drive,
  output logic [3:0] o_key,
  output logic       o_shift,
  output logic       o_key_func
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_EMIT     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [DEB_W-1:0] r_deb;
  logic [3:0]       r_row;
  logic [1:0]       r_row_idx;
  logic [2:0]       r_col;
  logic [3:0]       r_key;
  logic             r_shift;
`ifdef KEYPAD_FUNC_EN
  logic             r_func;
`endif

  logic       w_one_hot;
  logic [1:0] w_col_idx;
  logic [3:0] w_code;
  logic       w_is_func;

  always_comb begin
    w_one_hot = (i_col_in == 3'b001) || (i_col_in == 3'b010) || (i_col_in == 3'b100);
    w_col_idx = r_col[0] ? 2'd0 : (r_col[1] ? 2'd1 : 2'd2);
    w_code    = 4'h0;
    w_is_func = 1'b0;
    if (r_row_idx == 2'd3) begin
      // bottom row is "* 0 #"
      case (w_col_idx)
        2'd0:    begin w_code = 4'hA; w_is_func = 1'b1; end
        2'd1:    w_code = 4'h0;
        default: begin w_code = 4'hB; w_is_func = 1'b1; end
      endcase
    end else begin
      w_code = {2'b00, r_row_idx} * 4'd3 + {2'b00, w_col_idx} + 4'd1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_SCAN;
      r_div     <= '0;
      r_deb     <= '0;
      r_row     <= 4'b0001;
      r_row_idx <= 2'd0;
      r_col     <= 3'b000;
      r_key     <= 4'h0;
      r_shift   <= 1'b0;
`ifdef KEYPAD_FUNC_EN
      r_func    <= 1'b0;
`endif
    end else begin
      r_shift <= 1'b0;
`ifdef KEYPAD_FUNC_EN
      r_func  <= 1'b0;
`endif
      case (r_state)
        S_SCAN: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (w_one_hot) begin
              r_col   <= i_col_in;
              r_deb   <= '0;
              r_state <= S_DEBOUNCE;
            end else begin
              r_row     <= {r_row[2:0], r_row[3]};
              r_row_idx <= r_row_idx + 2'd1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_DEBOUNCE: begin
          if (i_col_in == r_col) begin
            if (r_deb == DEB_LAST) begin
              // pulse and code land together, in the EMIT cycle
              r_deb   <= '0;
              r_state <= S_EMIT;
`ifdef KEYPAD_FUNC_EN
              r_key   <= w_code;
              r_shift <= ~w_is_func;
              r_func  <= w_is_func;
`else
              if (!w_is_func) begin
                r_key   <= w_code;
                r_shift <= 1'b1;
              end
`endif
            end else begin
              r_deb <= r_deb + DEB_W'(1);
            end
          end else begin
            r_deb     <= '0;
            r_state   <= S_SCAN;
            r_row     <= {r_row[2:0], r_row[3]};
            r_row_idx <= r_row_idx + 2'd1;
          end
        end
        S_EMIT: begin
          r_deb   <= '0;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (i_col_in == 3'b000) begin
            if (r_deb == DEB_LAST) begin
              r_deb     <= '0;
              r_state   <= S_SCAN;
              r_row     <= {r_row[2:0], r_row[3]};
              r_row_idx <= r_row_idx + 2'd1;
            end else begin
              r_deb <= r_deb + DEB_W'(1);
            end
          end else begin
            r_deb <= '0;
          end
        end
        default: r_state <= S_SCAN;
      endcase
    end
  end

  assign o_row_drive = r_row;
  assign o_key       = r_key;
  assign o_shift     = r_shift;
`ifdef KEYPAD_FUNC_EN
  assign o_key_func  = r_func;
`else
  assign o_key_func  = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical key-matrix model, event scoreboard, directed and random presses.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DC = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] col_in;
  logic [3:0] row_drive, key;
  logic       shift, key_func;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .i_clock(clock), .i_reset(reset), .i_col_in(col_in),
    .o_row_drive(row_drive), .o_key(key), .o_shift(shift), .o_key_func(key_func)
  );

  // Key matrix: a pressed key connects its row strobe to its column line.
  logic       pvalid = 1'b0;
  logic [1:0] prow = 2'd0, pcol = 2'd0;
  logic       ovr_en = 1'b0;
  logic [2:0] ovr = 3'b000;
  always_comb begin
    col_in = 3'b000;
    if (ovr_en) col_in = ovr;
    else if (pvalid && row_drive[prow]) col_in = 3'(3'b001 << pcol);
  end

  logic [4:0] ev_q[$];
  int n_shift = 0, n_func = 0, n_both = 0;
  always @(negedge clock) begin
    if (shift) begin n_shift++; ev_q.push_back({1'b0, key}); end
    if (key_func) begin n_func++; ev_q.push_back({1'b1, key}); end
    if (shift && key_func) n_both++;
  end

  logic        dclr = 1'b0;
  logic [15:0] dreg = 16'h0;
  always @(posedge clock) begin
    if (dclr) dreg <= 16'h0;
    else if (shift) dreg <= {dreg[11:0], key};
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] ref_code(input int idx);
    if (idx < 9) return 4'(idx + 1);
    if (idx == 9) return 4'hA;
    if (idx == 10) return 4'h0;
    return 4'hB;
  endfunction

  function automatic bit ref_func(input int idx);
    return (idx == 9) || (idx == 11);
  endfunction

  task automatic press(input int idx);
    prow = 2'(idx / 3);
    pcol = 2'(idx % 3);
    pvalid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rst_seq();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [4:0] exp_q[$];
  logic [3:0] exp_key;
  int pcyc, s0, idx;
  bit found;

  initial begin
    // reset state and first row advance
    repeat (3) @(posedge clock);
    #1;
    chk("rst_row", 32'(row_drive), 32'h1);
    chk("rst_key", 32'(key), 32'h0);
    chk("rst_shift", 32'(shift), 32'h0);
    chk("rst_func", 32'(key_func), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle(3);
    chk("row0_hold", 32'(row_drive), 32'h1);
    idle(1);
    chk("row1_step", 32'(row_drive), 32'h2);

    // single '1' press, exact latency, no repeat
    rst_seq();
    press(0);
    ev_q.delete();
    s0 = n_shift;
    pcyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (shift && pcyc < 0) pcyc = n;
    end
    pvalid = 1'b0;
    idle(40);
    chk("lat_1", 32'(pcyc), 32'd12);
    chk("pulses_1", 32'(n_shift - s0), 32'd1);
    chk("ev_1", 32'(ev_q.size() > 0 ? ev_q[0] : 5'h1F), 32'h01);
    chk("key_1", 32'(key), 32'h1);

    // 1,2,3,4 into downstream register
    ev_q.delete();
    dclr = 1'b1; idle(1); dclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      press(i); idle(40);
      pvalid = 1'b0; idle(40);
    end
    chk("n_1234", 32'(ev_q.size()), 32'd4);
    chk("dreg_1234", 32'(dreg), 32'h1234);

    // glitch in row1, then a two-column press
    ev_q.delete();
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clock); #1;
      if (row_drive == 4'b0010) begin found = 1'b1; break; end
    end
    chk("row1_seen", 32'(found), 32'd1);
    ovr = 3'b010; ovr_en = 1'b1; idle(5);
    ovr_en = 1'b0; idle(30);
    ovr = 3'b011; ovr_en = 1'b1; idle(60);
    ovr_en = 1'b0; idle(30);
    chk("glitch_ev", 32'(ev_q.size()), 32'd0);
    chk("glitch_key", 32'(key), 32'h4);

    // '#'
    ev_q.delete();
    s0 = n_shift;
    press(11); idle(60);
    pvalid = 1'b0; idle(40);
    chk("hash_noshift", 32'(n_shift - s0), 32'd0);
`ifdef KEYPAD_FUNC_EN
    chk("hash_ev_n", 32'(ev_q.size()), 32'd1);
    chk("hash_ev", 32'(ev_q.size() > 0 ? ev_q[0] : 5'h00), 32'h1B);
    chk("hash_key", 32'(key), 32'hB);
    exp_key = 4'hB;
`else
    chk("hash_ev_n", 32'(ev_q.size()), 32'd0);
    chk("hash_key", 32'(key), 32'h4);
    exp_key = 4'h4;
`endif

    // random presses against the event model
    ev_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      idx = int'($urandom_range(0, 11));
      press(idx);
      idle(int'($urandom_range(40, 80)));
      pvalid = 1'b0;
      idle(int'($urandom_range(30, 50)));
      if (!ref_func(idx)) begin
        exp_q.push_back({1'b0, ref_code(idx)});
        exp_key = ref_code(idx);
      end else begin
`ifdef KEYPAD_FUNC_EN
        exp_q.push_back({1'b1, ref_code(idx)});
        exp_key = ref_code(idx);
`endif
      end
    end
    chk("rnd_n", 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      chk($sformatf("rnd_ev%0d", i), 32'(ev_q[i]), 32'(exp_q[i]));
    chk("rnd_key", 32'(key), 32'(exp_key));

    // reset in the middle of debouncing a '5'
    rst_seq();
    press(4);
    s0 = n_shift;
    idle(11);
    reset = 1'b1;
    #1;
    chk("abort_row", 32'(row_drive), 32'h1);
    chk("abort_key", 32'(key), 32'h0);
    chk("abort_shift", 32'(shift), 32'h0);
    chk("abort_func", 32'(key_func), 32'h0);
    idle(3);
    pvalid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    idle(5);
    chk("abort_nopulse", 32'(n_shift - s0), 32'd0);
    ev_q.delete();
    press(4); idle(50);
    pvalid = 1'b0; idle(40);
    chk("fresh5_n", 32'(ev_q.size()), 32'd1);
    chk("fresh5_key", 32'(key), 32'h5);

    chk("never_both", 32'(n_both), 32'd0);
`ifndef KEYPAD_FUNC_EN
    chk("func_tied", 32'(n_func), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
